inst_fetch_stage: RTL

// Instruction-fetch front end that sits directly upstream of inst_ram.
// - Holds the fetch PC and drives inst_ram's word address.
// - Captures the combinational read data (spo) together with its PC.
// - Buffers up to BUF_DEPTH fetched instructions and hands them to decode

---
 rtl/inst_fetch_stage.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_stage
// Description : Instruction-fetch front end placed directly upstream of
//               inst_ram. Owns the fetch PC, drives the RAM word address,
//               captures the combinational read data together with its PC
//               into a small instruction buffer, and hands buffered entries
//               to decode over a valid/ready handshake. Branch redirects
//               flush the buffer; a misaligned fetch PC produces a single
//               fault entry and parks the fetcher until the next redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_stage #(
  parameter int          ADDR_WIDTH = 15,
  parameter logic [31:0] PC_RESET   = 32'h1c000000,
  parameter int          BUF_DEPTH  = 2,
  parameter logic [31:0] NOP_INST   = 32'h03400000
) (
  input  logic                  clk,
  input  logic                  resetn,
  // inst_ram side
  output logic [ADDR_WIDTH-1:0] irom_a,
  output logic                  irom_we,
  output logic [31:0]           irom_d,
  input  logic [31:0]           irom_spo,
  // redirect from execute
  input  logic                  br_taken,
  input  logic [31:0]           br_target,
  // decode side
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [31:0]           id_pc,
  output logic [31:0]           id_inst,
  output logic                  id_adef
);

  // --------------------------------------------------------------------------
  // Derived constants. BUF_DEPTH is a power of two, so the pointers wrap
  // naturally at their own width; the count needs one extra bit to hold
  // the "full" value.
  // --------------------------------------------------------------------------
  localparam int                 c_ptr_w   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int                 c_cnt_w   = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(BUF_DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [31:0]        c_pc_step = 32'd4;

  // Fetcher state: RUN issues fetches, HALT waits for a redirect after a
  // misaligned-PC fault has been queued.
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [31:0]         r_fetch_pc;
  logic [31:0]         w_fetch_pc_nxt;

  logic [c_cnt_w-1:0]  r_count;
  logic [c_cnt_w-1:0]  w_count_nxt;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_ptr_w-1:0]  w_rd_ptr_nxt;
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  w_wr_ptr_nxt;

  // Buffer storage; contents are only meaningful where count says so, so
  // the arrays carry no reset.
  logic [31:0]         r_buf_pc   [BUF_DEPTH];
  logic [31:0]         r_buf_inst [BUF_DEPTH];
  logic                r_buf_adef [BUF_DEPTH];

  logic                w_pop;
  logic                w_room;
  logic                w_misaligned;
  logic                w_push;
  logic                w_fault;
  logic [31:0]         w_push_inst;

  // --------------------------------------------------------------------------
  // Handshake terms. id_valid comes straight from the occupancy count: there
  // is no bypass path from irom_spo to decode.
  // --------------------------------------------------------------------------
  assign id_valid     = (r_count != '0);
  assign w_pop        = id_valid & id_ready;
  // A full buffer still accepts a new entry when the head leaves this cycle.
  assign w_room       = (r_count < c_depth) | w_pop;
  assign w_misaligned = (r_fetch_pc[1:0] != 2'b00);

  // Next-state and push decision; a redirect suppresses any push this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_fault     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (br_taken) begin
          w_state_nxt = ST_RUN;
        end else if (w_room) begin
          w_push = 1'b1;
          if (w_misaligned) begin
            w_fault     = 1'b1;
            w_state_nxt = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        if (br_taken) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Fetcher state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch PC, count and pointer updates; a redirect flushes the buffer.
  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    w_count_nxt    = r_count;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_wr_ptr_nxt   = r_wr_ptr;
    if (br_taken) begin
      w_fetch_pc_nxt = br_target;
      w_count_nxt    = '0;
      w_rd_ptr_nxt   = '0;
      w_wr_ptr_nxt   = '0;
    end else begin
      // A faulting fetch holds the PC so the fault entry names the bad PC.
      if (w_push && !w_fault) begin
        w_fetch_pc_nxt = r_fetch_pc + c_pc_step;
      end
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + c_cnt_one;
        2'b01:   w_count_nxt = r_count - c_cnt_one;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Fetch PC, occupancy and pointer registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_fetch_pc <= PC_RESET;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
      r_count    <= w_count_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
    end
  end

  // Fault entries carry a harmless NOP in place of the RAM data.
  assign w_push_inst = w_fault ? NOP_INST : irom_spo;

  // Buffer write port: capture PC, instruction and fault flag at wr_ptr.
  always_ff @(posedge clk) begin
    if (resetn && w_push) begin
      r_buf_pc[r_wr_ptr]   <= r_fetch_pc;
      r_buf_inst[r_wr_ptr] <= w_push_inst;
      r_buf_adef[r_wr_ptr] <= w_fault;
    end
  end

  // --------------------------------------------------------------------------
  // Decode-side outputs read as zero whenever the head is not valid.
  // --------------------------------------------------------------------------
  assign id_pc   = id_valid ? r_buf_pc[r_rd_ptr]   : 32'd0;
  assign id_inst = id_valid ? r_buf_inst[r_rd_ptr] : 32'd0;
  assign id_adef = id_valid ? r_buf_adef[r_rd_ptr] : 1'b0;

  // --------------------------------------------------------------------------
  // RAM side: word address is the truncated fetch PC; the port never writes.
  // --------------------------------------------------------------------------
  assign irom_a  = r_fetch_pc[ADDR_WIDTH+1:2];
  assign irom_we = 1'b0;
  assign irom_d  = 32'd0;

endmodule
`default_nettype wire
